stdp_lut_arbiter: RTL and testbench
===================================

Name: stdp_lut_arbiter

Overview:
Shares the single registered STDP depression LUT (8-bit dt in, 24-bit weight decrement out, 1-cycle registered latency) among NREQ synapse-update requesters. Uses round-robin arbitration and accepts at most one request per cycle. Drives the LUT input from a register and tags each in-flight lookup with the requester id. Returns the LUT result on a shared response bus with a valid strobe. Sits between the per-synapse STDP update logic and the LUT instance in the SNN core.

Parameters:
NREQ, 4, number of requesters (2..16)
DT_W, 8, width of the dt operand and of lut_in
LUT_W, 24, width of the LUT result
LUT_LAT, 1, registered latency of the LUT (cycles from lut_in stable to lut_out valid)
CNT_W, 16, width of the grant statistics counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  global enable; 0 blocks new grants while the in-flight pipeline still drains
req  in  NREQ  per-requester request, level; hold until granted
req_dt  in  NREQ*DT_W  flattened dt operands; requester i at bits [i*DT_W +: DT_W]
gnt  out  NREQ  one-hot grant, combinational, same cycle as acceptance
lut_in  out  DT_W  registered operand to LUT
lut_out  in  LUT_W  LUT result
rsp_valid  out  1  one-cycle pulse, result available
rsp_id  out  ID_W  requester id of the result; ID_W = max(1, clog2(NREQ))
rsp_data  out  LUT_W  LUT result forwarded to the requester
busy  out  1  high while any lookup is in flight
grant_count  out  CNT_W  total grants since reset, saturating

Behaviour:
- Reset (rst=1 at a clk edge): lut_in=0, round-robin pointer=0, all pipeline valids=0, rsp_valid=0, rsp_id=0, rsp_data=0, grant_count=0, busy=0. Output gnt=0 while rst=1.
- Reset mid-operation discards all in-flight lookups. No rsp_valid is produced for them.
- Arbitration in cycle C, when en=1 and req!=0:
  - Winner w is the first set req bit searching from the pointer upward, wrapping at NREQ-1 to 0.
  - gnt[w]=1 in cycle C.
  - At the end of C: pointer <= (w+1) mod NREQ, lut_in <= req_dt[w], tag pipe stage 0 <= {valid=1, id=w}.
- When en=0 or req=0: gnt=0, pointer holds, lut_in holds its last value, stage 0 valid <= 0.
- Handshake:
  - A request is accepted in exactly the cycle gnt[i]=1.
  - A requester may deassert req or change req_dt from cycle C+1.
  - A requester that keeps req high is granted again only after the others have had their turn.
- Tag pipeline: LUT_LAT+1 stages of {valid, id}, which tracks lut_in register plus LUT latency.
- Response: for a grant in cycle C, rsp_valid=1 in cycle C+1+LUT_LAT (C+2 by default).
  - rsp_id=w, rsp_data=lut_out sampled combinationally from the LUT in that cycle.
  - rsp_data and rsp_id are 0 whenever rsp_valid=0.
- Throughput: one grant and one response per cycle, sustained. Back-to-back grants to different requesters return in grant order.
- Out-of-range dt (anything other than 2..20) is passed through unchanged. The LUT returns 0 and the block forwards 0 with rsp_valid=1. There is no filtering.
- busy = OR of all tag-stage valids.
- grant_count increments on every grant and saturates at 2^CNT_W-1.
- No backpressure on the response bus: requesters must accept rsp in its valid cycle.

Decomposition:
- Shared header include holds: DT_W, LUT_W, DT_MIN=2, DT_MAX=20, LUT_LAT=1. The LUT and this block use the same header.
- One sub-module, rr_arbiter: NREQ parameter, req in, en in, one-hot gnt out, encoded winner id out, registered rotating pointer.
- Operand muxing, tag pipeline and counter stay in stdp_lut_arbiter.

Test Plan:
- Reset then idle: all outputs 0, busy=0, lut_in=0 for 10 cycles with req=0.
- Single request, NREQ=4: req=0001, dt0=5 in cycle C → gnt=0001 in C; rsp_valid in C+2 with rsp_id=0, rsp_data=180 (0xB4); grant_count=1.
- All four requesting continuously, dt0..3=2,3,4,20 → grants in order 0,1,2,3,0,...; responses one per cycle, 329, 269, 220, 9, repeating.
- Rotation fairness: req=1010 held → grants alternate 1,3,1,3; pointer wrap from 3 back to 1 verified.
- Out-of-range operand: dt=1 and dt=21 → rsp_valid pulses with rsp_data=0; dt=0x14 (20) → 9.
- Reset mid-flight: grant in cycle C, rst=1 in C+1 → no rsp_valid in C+2, busy=0 after reset. Also: en=0 while req=1111 → gnt=0, and the pipeline drains the previous grant normally.

Source files
------------

// File: rtl/stdp_lut_arbiter_pkg.sv
// Constants shared by the STDP depression LUT and the requester arbiter that fronts it.
package stdp_lut_arbiter_pkg;

  localparam int DT_W    = 8;
  localparam int LUT_W   = 24;
  localparam int DT_MIN  = 2;
  localparam int DT_MAX  = 20;
  localparam int LUT_LAT = 1;

  // Requester id width; a lone requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stdp_lut_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded winner, pointer moves just past the winner.
module rr_arbiter
  import stdp_lut_arbiter_pkg::*;
#(
  parameter int  NREQ = 4,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_id,
  output logic            o_grant
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_idx;
  logic [ID_W-1:0] w_id;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            w_found;
  logic            w_grant;

  // Search from the pointer upward, wrapping at NREQ-1, for the first active request.
  always_comb begin
    w_idx   = '0;
    w_id    = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NREQ)) begin
        w_idx = w_idx - (ID_W+1)'(NREQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_id    = w_idx[ID_W-1:0];
      end else begin
        w_found = w_found;
      end
    end
    w_grant = w_found && i_en && !rst;
    if (w_id == ID_W'(NREQ-1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_id + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Pointer only advances on an actual grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_ptr_nxt;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_gnt   = w_grant ? (NREQ'(1) << w_id) : '0;
  assign o_id    = w_id;
  assign o_grant = w_grant;

endmodule

// File: rtl/stdp_lut_arbiter.sv
// Shares one registered STDP depression LUT among NREQ requesters: registered operand,
// {valid,id} tag pipeline matched to the LUT latency, tagged response bus, grant statistics.
module stdp_lut_arbiter
  import stdp_lut_arbiter_pkg::*;
#(
  parameter int  NREQ  = 4,
  parameter int  CNT_W = 16,
  localparam int ID_W  = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*DT_W-1:0] i_req_dt,
  output logic [NREQ-1:0]      o_gnt,
  output logic [DT_W-1:0]      o_lut_in,
  input  logic [LUT_W-1:0]     i_lut_out,
  output logic                 o_rsp_valid,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [LUT_W-1:0]     o_rsp_data,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_grant_count
);

  logic [ID_W-1:0]             w_id;
  logic                        w_grant;
  logic [DT_W-1:0]             w_dt;
  logic [DT_W-1:0]             r_lut_in;
  logic [LUT_LAT:0]            r_vld;
  logic [LUT_LAT:0][ID_W-1:0]  r_id;
  logic [CNT_W-1:0]            r_cnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_en),
    .i_req   (i_req),
    .o_gnt   (o_gnt),
    .o_id    (w_id),
    .o_grant (w_grant)
  );

  assign w_dt = i_req_dt[w_id*DT_W +: DT_W];

  // Operand register holds the last granted dt when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lut_in <= '0;
    end else if (w_grant) begin
      r_lut_in <= w_dt;
    end else begin
      r_lut_in <= r_lut_in;
    end
  end

  // Stage 0 lines up with the operand register, the last stage with the LUT result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_grant;
      r_id[0]  <= w_grant ? w_id : '0;
      for (int i = 1; i <= LUT_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  // Saturating grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_grant && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_lut_in      = r_lut_in;
  assign o_rsp_valid   = r_vld[LUT_LAT];
  assign o_rsp_id      = r_vld[LUT_LAT] ? r_id[LUT_LAT] : '0;
  assign o_rsp_data    = r_vld[LUT_LAT] ? i_lut_out : '0;
  assign o_busy        = |r_vld;
  assign o_grant_count = r_cnt;

endmodule

// File: tb/tb_stdp_lut_arbiter.sv
// Bench for stdp_lut_arbiter: directed vector table plus randomized traffic against a
// cycle-indexed reference model; a registered LUT model stands in for the real table.
module tb_stdp_lut_arbiter;
  localparam int NREQ  = 4;
  localparam int DT_W  = 8;
  localparam int LUT_W = 24;
  localparam int ID_W  = 2;
  localparam int CNT_W = 6;
  localparam int HORIZON = 8192;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DT_W-1:0] req_dt = '0;
  logic [NREQ-1:0]      gnt;
  logic [DT_W-1:0]      lut_in;
  logic [LUT_W-1:0]     lut_out = '0;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [LUT_W-1:0]     rsp_data;
  logic                 busy;
  logic [CNT_W-1:0]     grant_count;

  int total = 0;
  int bad   = 0;

  stdp_lut_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (en),
    .i_req         (req),
    .i_req_dt      (req_dt),
    .o_gnt         (gnt),
    .o_lut_in      (lut_in),
    .i_lut_out     (lut_out),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_id      (rsp_id),
    .o_rsp_data    (rsp_data),
    .o_busy        (busy),
    .o_grant_count (grant_count)
  );

  always #5 clk = ~clk;

  // Depression LUT: roughly 491*exp(-dt/5) over dt 2..20, zero elsewhere.
  function automatic logic [LUT_W-1:0] lut_ref(input logic [7:0] dt);
    case (dt)
      8'd2:  return 24'd329;  8'd3:  return 24'd269;  8'd4:  return 24'd220;
      8'd5:  return 24'd180;  8'd6:  return 24'd147;  8'd7:  return 24'd121;
      8'd8:  return 24'd99;   8'd9:  return 24'd81;   8'd10: return 24'd66;
      8'd11: return 24'd54;   8'd12: return 24'd44;   8'd13: return 24'd36;
      8'd14: return 24'd29;   8'd15: return 24'd24;   8'd16: return 24'd20;
      8'd17: return 24'd16;   8'd18: return 24'd13;   8'd19: return 24'd10;
      8'd20: return 24'd9;
      default: return 24'd0;
    endcase
  endfunction

  always @(posedge clk) lut_out <= lut_ref(lut_in);

  // Reference model state: expected responses indexed by the cycle they must appear in.
  int   cyc = 0;
  int   ptr = 0;
  int   m_cnt = 0;
  int   m_lut_in = 0;
  bit   pv    [HORIZON];
  int   pid   [HORIZON];
  int   pdata [HORIZON];

  logic [NREQ-1:0]  s_gnt;
  logic             s_rv;
  logic [ID_W-1:0]  s_rid;
  logic [LUT_W-1:0] s_rdata;
  logic             s_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [NREQ-1:0] q,
                      input logic [NREQ*DT_W-1:0] d);
    int win;
    int idx;
    logic [NREQ-1:0] eg;
    rst = r; en = e; req = q; req_dt = d;
    @(negedge clk);
    s_gnt = gnt; s_rv = rsp_valid; s_rid = rsp_id; s_rdata = rsp_data; s_busy = busy;
    win = -1;
    if (!r && e) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (ptr + k) % NREQ;
        if (win < 0 && q[idx]) win = idx;
      end
    end
    eg = (win >= 0) ? (NREQ'(1) << win) : '0;
    chk("gnt",         64'(s_gnt),       64'(eg));
    chk("rsp_valid",   64'(s_rv),        64'(pv[cyc]));
    chk("rsp_id",      64'(s_rid),       pv[cyc] ? 64'(pid[cyc]) : 64'd0);
    chk("rsp_data",    64'(s_rdata),     pv[cyc] ? 64'(pdata[cyc]) : 64'd0);
    chk("busy",        64'(s_busy),      64'(pv[cyc] | pv[cyc+1]));
    chk("lut_in",      64'(lut_in),      64'(m_lut_in));
    chk("grant_count", 64'(grant_count), 64'(m_cnt));
    if (r) begin
      ptr = 0; m_cnt = 0; m_lut_in = 0;
      pv[cyc+1] = 1'b0; pv[cyc+2] = 1'b0;
    end else if (win >= 0) begin
      ptr = (win + 1) % NREQ;
      m_lut_in = int'(d[win*DT_W +: DT_W]);
      m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
      pv[cyc+2] = 1'b1;
      pid[cyc+2] = win;
      pdata[cyc+2] = int'(lut_ref(d[win*DT_W +: DT_W]));
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r; logic e; logic [3:0] q; logic [31:0] d;
    logic [3:0] g; logic v; int id; int data; logic b;
  } vec_t;

  localparam logic [31:0] D_A = 32'h0000_0005;
  localparam logic [31:0] D_B = 32'h1404_0302;
  localparam logic [31:0] D_C = 32'h1500_0100;
  localparam logic [31:0] D_D = 32'h0000_0014;
  localparam logic [31:0] D_E = 32'h0005_0000;

  vec_t tv [27];

  initial begin
    tv[0]  = '{1'b0, 1'b1, 4'b0001, D_A, 4'b0001, 1'b0, 0, 0,   1'b0};
    tv[1]  = '{1'b0, 1'b1, 4'b0000, D_A, 4'b0000, 1'b0, 0, 0,   1'b1};
    tv[2]  = '{1'b0, 1'b1, 4'b0000, D_A, 4'b0000, 1'b1, 0, 180, 1'b1};
    tv[3]  = '{1'b1, 1'b1, 4'b0000, D_A, 4'b0000, 1'b0, 0, 0,   1'b0};
    tv[4]  = '{1'b0, 1'b1, 4'b1111, D_B, 4'b0001, 1'b0, 0, 0,   1'b0};
    tv[5]  = '{1'b0, 1'b1, 4'b1111, D_B, 4'b0010, 1'b0, 0, 0,   1'b1};
    tv[6]  = '{1'b0, 1'b1, 4'b1111, D_B, 4'b0100, 1'b1, 0, 329, 1'b1};
    tv[7]  = '{1'b0, 1'b1, 4'b1111, D_B, 4'b1000, 1'b1, 1, 269, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 4'b1111, D_B, 4'b0001, 1'b1, 2, 220, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 4'b1111, D_B, 4'b0010, 1'b1, 3, 9,   1'b1};
    tv[10] = '{1'b0, 1'b1, 4'b0000, D_B, 4'b0000, 1'b1, 0, 329, 1'b1};
    tv[11] = '{1'b0, 1'b1, 4'b0000, D_B, 4'b0000, 1'b1, 1, 269, 1'b1};
    tv[12] = '{1'b0, 1'b1, 4'b0000, D_B, 4'b0000, 1'b0, 0, 0,   1'b0};
    tv[13] = '{1'b0, 1'b1, 4'b1010, D_C, 4'b1000, 1'b0, 0, 0,   1'b0};
    tv[14] = '{1'b0, 1'b1, 4'b1010, D_C, 4'b0010, 1'b0, 0, 0,   1'b1};
    tv[15] = '{1'b0, 1'b1, 4'b1010, D_C, 4'b1000, 1'b1, 3, 0,   1'b1};
    tv[16] = '{1'b0, 1'b1, 4'b1010, D_C, 4'b0010, 1'b1, 1, 0,   1'b1};
    tv[17] = '{1'b0, 1'b1, 4'b0000, D_C, 4'b0000, 1'b1, 3, 0,   1'b1};
    tv[18] = '{1'b0, 1'b1, 4'b0000, D_C, 4'b0000, 1'b1, 1, 0,   1'b1};
    tv[19] = '{1'b0, 1'b1, 4'b0001, D_D, 4'b0001, 1'b0, 0, 0,   1'b0};
    tv[20] = '{1'b0, 1'b0, 4'b1111, D_B, 4'b0000, 1'b0, 0, 0,   1'b1};
    tv[21] = '{1'b0, 1'b0, 4'b1111, D_B, 4'b0000, 1'b1, 0, 9,   1'b1};
    tv[22] = '{1'b0, 1'b0, 4'b1111, D_B, 4'b0000, 1'b0, 0, 0,   1'b0};
    tv[23] = '{1'b0, 1'b1, 4'b0100, D_E, 4'b0100, 1'b0, 0, 0,   1'b0};
    tv[24] = '{1'b1, 1'b1, 4'b0000, D_E, 4'b0000, 1'b0, 0, 0,   1'b1};
    tv[25] = '{1'b0, 1'b1, 4'b0000, D_E, 4'b0000, 1'b0, 0, 0,   1'b0};
    tv[26] = '{1'b0, 1'b1, 4'b0000, D_E, 4'b0000, 1'b0, 0, 0,   1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Idle after reset: everything must stay at zero.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'b0000, 32'h0);

    // Directed vectors with hand-derived expectations (the model also checks each cycle).
    for (int i = 0; i < 27; i++) begin
      step(tv[i].r, tv[i].e, tv[i].q, tv[i].d);
      chk($sformatf("tv%0d.gnt", i),       64'(s_gnt),   64'(tv[i].g));
      chk($sformatf("tv%0d.rsp_valid", i), 64'(s_rv),    64'(tv[i].v));
      chk($sformatf("tv%0d.rsp_id", i),    64'(s_rid),   64'(tv[i].id));
      chk($sformatf("tv%0d.rsp_data", i),  64'(s_rdata), 64'(tv[i].data));
      chk($sformatf("tv%0d.busy", i),      64'(s_busy),  64'(tv[i].b));
    end

    // Randomized traffic, with occasional enable drops and mid-flight resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NREQ*DT_W-1:0] d;
      for (int j = 0; j < NREQ; j++) d[j*DT_W +: DT_W] = DT_W'($urandom_range(0, 23));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           NREQ'($urandom), d);
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0000, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
